seg7_scan_ctrl: RTL and testbench
=================================

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 8: number of multiplexed digits; legal 2..16.
REQ-002 Parameter REFRESH_DIV, default 4096: clk cycles each digit is held; legal 2..65536.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  scan enable; low blanks all digits and freezes the scan.
REQ-006 value  input  4*NUM_DIGITS  hex nibbles; nibble k (bits 4k+3:4k) drives digit k.
REQ-007 load  input  1  single-cycle strobe capturing value and dp_mask.
REQ-008 dp_mask  input  NUM_DIGITS  decimal-point request per digit; 1 = lit.
REQ-009 blank_lz  input  1  leading-zero blanking mode, level-sensitive.
REQ-010 Display  output  7  active-low segments {g,f,e,d,c,b,a}, registered.
REQ-011 Dp  output  1  active-low decimal point, registered.
REQ-012 Seg  output  NUM_DIGITS  active-low one-hot digit select, registered.
REQ-013 frame_done  output  1  one-cycle pulse at end of every full scan.

Function
REQ-014 Prescaler counts 0..REFRESH_DIV-1 and wraps; tick is asserted when it equals REFRESH_DIV-1.
REQ-015 Digit index idx advances by 1 on each tick and wraps from NUM_DIGITS-1 to 0.
REQ-016 A tick with idx = NUM_DIGITS-1 is a frame boundary; frame_done is high in the cycle after that boundary only.
REQ-017 On load, value and dp_mask are written to a pending register; the displayed (active) register is not changed by load alone.
REQ-018 At a frame boundary, active takes value/dp_mask if load is high in that cycle, otherwise it takes pending.
REQ-019 While enable is low, a load also writes active directly, so the first frame after enable rises shows the latest data.
REQ-020 Outputs are registered: Display, Dp and Seg reflect idx and active from the previous cycle (1-cycle latency).
REQ-021 Seg drives bit idx low and all other bits high; exactly one bit is low while enable is high.
REQ-022 Hex decode: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, B=0000011, C=1000110, D=0100001, E=0000110, F=0001110.
REQ-023 When blank_lz is high, any digit above the most significant nonzero nibble of active drives Display=1111111; digit 0 is never blanked.
REQ-024 Dp follows active dp_mask[idx] (low = lit) and is not affected by blank_lz.
REQ-025 When enable is low: prescaler=0, idx=0, Seg all ones, Display=1111111, Dp=1, frame_done=0; when enable rises, scan starts at digit 0 with a full REFRESH_DIV dwell.
REQ-026 Counter widths are $clog2 of their range; no overflow is possible for any legal parameter value.

Reset
REQ-027 reset is checked before enable and has priority over load, enable and tick.
REQ-028 Reset values: prescaler=0, idx=0, pending=0, active=0 (including dp bits), Display=1111111, Dp=1, Seg all ones, frame_done=0.
REQ-029 Reset asserted mid-frame drops any pending data; the first frame after reset shows active=0.

Verification (NUM_DIGITS=4, REFRESH_DIV=4)
REQ-030 Reset, then enable=1 with no load -> Seg sequence 1110,1101,1011,0111 with 4 cycles per digit; Display=1000000 on every digit; frame_done pulses every 16 cycles.
REQ-031 enable=0, load value=16'h12AF -> after enable rises, digit0=0001110, digit1=0001000, digit2=0100100, digit3=1111001.
REQ-032 Mid-frame load of 16'h0005 while 16'h1111 is shown -> remainder of the current frame shows 1; the next frame shows 5,0,0,0.
REQ-033 blank_lz=1, active=16'h0050 -> digits 3 and 2 show 1111111, digit1=0010010, digit0=1000000; active=0 -> only digit0 is lit, showing 1000000.
REQ-034 dp_mask=4'b0100 -> Dp=0 only while Seg=1011; load coincident with frame boundary -> the new value is shown from the next digit0.
REQ-035 reset pulsed during digit 2 -> the next cycle shows reset values; the scan restarts at digit0 showing 0.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed 7-segment scan controller with hex decode,
// double-buffered display data, decimal points and leading-zero blanking.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 4096
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    blank_lz,
  output logic [6:0]              Display,
  output logic                    Dp,
  output logic [NUM_DIGITS-1:0]   Seg,
  output logic                    frame_done
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [4*NUM_DIGITS-1:0] act_val_q, act_val_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [6:0]              disp_q, disp_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   seg_q, seg_d;
  logic                    frame_done_q, frame_done_d;

  logic                    tick;
  logic                    frame_end;
  logic [IW-1:0]           msnz;
  logic [3:0]              cur_nibble;
  logic                    blank_digit;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign tick      = enable && (presc_q == PRESC_LAST);
  assign frame_end = tick && (idx_q == IDX_LAST);

  // Position of the most significant nonzero nibble; stays 0 when all are zero
  // so digit 0 is never blanked.
  always_comb begin
    msnz = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (act_val_q[4*k +: 4] != 4'h0) msnz = IW'(k);
    end
  end

  assign cur_nibble  = act_val_q[{idx_q, 2'b00} +: 4];
  assign blank_digit = blank_lz && (idx_q > msnz);

  always_comb begin
    presc_d      = presc_q;
    idx_d        = idx_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    act_val_d    = act_val_q;
    act_dp_d     = act_dp_q;
    disp_d       = 7'b1111111;
    dp_d         = 1'b1;
    seg_d        = '1;
    frame_done_d = 1'b0;

    if (load) begin
      pend_val_d = value;
      pend_dp_d  = dp_mask;
    end

    if (!enable) begin
      presc_d = '0;
      idx_d   = '0;
      // Loads while idle go straight to the display so the first frame is fresh.
      if (load) begin
        act_val_d = value;
        act_dp_d  = dp_mask;
      end
    end else begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      if (frame_end) begin
        act_val_d = load ? value : pend_val_q;
        act_dp_d  = load ? dp_mask : pend_dp_q;
      end
      frame_done_d = frame_end;
      seg_d        = ~(NUM_DIGITS'(1) << idx_q);
      disp_d       = blank_digit ? 7'b1111111 : hex7(cur_nibble);
      dp_d         = ~act_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q      <= '0;
      idx_q        <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      disp_q       <= 7'b1111111;
      dp_q         <= 1'b1;
      seg_q        <= '1;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      disp_q       <= disp_d;
      dp_q         <= dp_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign Display    = disp_q;
  assign Dp         = dp_q;
  assign Seg        = seg_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - directed bench for seg7_scan_ctrl, 4 digits, 4-cycle dwell.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp_mask;
  logic        blank_lz;
  logic [6:0]  Display;
  logic        Dp;
  logic [3:0]  Seg;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] val;
    logic [3:0]  dp;
    logic        blz;
    logic [27:0] disp;
    logic [3:0]  dpx;
  } vec_t;

  vec_t tbl[7];

  seg7_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .value(value), .load(load),
    .dp_mask(dp_mask), .blank_lz(blank_lz), .Display(Display), .Dp(Dp),
    .Seg(Seg), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  task automatic chk_blank(input string tag);
    chk({tag, "_seg"}, 32'(Seg), 32'hF);
    chk({tag, "_disp"}, 32'(Display), 32'h7F);
    chk({tag, "_dp"}, 32'(Dp), 32'h1);
    chk({tag, "_fd"}, 32'(frame_done), 32'h0);
  endtask

  task automatic load_idle(input logic [15:0] v);
    enable = 1'b0; load = 1'b1; value = v; dp_mask = 4'b0000;
    step();
    load = 1'b0; enable = 1'b1;
    step();
  endtask

  // Scan with enable already high and sample 0 just taken; an optional load is
  // applied after sample load_n. v0 is shown until sample 16, v1 after.
  task automatic scan_run(input string tag, input logic [15:0] v0, input int load_n,
                          input logic [15:0] v1, input int nsamp);
    logic [15:0] act;
    logic [3:0]  exp_seg;
    int d;
    for (int n = 0; n < nsamp; n++) begin
      d       = (n / 4) % 4;
      act     = (n >= 16) ? v1 : v0;
      exp_seg = 4'b1111 ^ (4'b0001 << d);
      chk($sformatf("%s_seg_n%0d", tag, n), 32'(Seg), 32'(exp_seg));
      chk($sformatf("%s_disp_n%0d", tag, n), 32'(Display), 32'(seg_of(act[4*d +: 4])));
      chk($sformatf("%s_fd_n%0d", tag, n), 32'(frame_done), 32'((n % 16) == 15));
      if (n == load_n) begin
        load = 1'b1; value = v1;
      end else begin
        load = 1'b0;
      end
      step();
    end
    load = 1'b0;
  endtask

  initial begin
    tbl[0] = '{16'h12AF, 4'b0000, 1'b0, {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}, 4'b1111};
    tbl[1] = '{16'h0050, 4'b0000, 1'b1, {7'b1111111, 7'b1111111, 7'b0010010, 7'b1000000}, 4'b1111};
    tbl[2] = '{16'h0000, 4'b0000, 1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 4'b1111};
    tbl[3] = '{16'h3456, 4'b0100, 1'b0, {7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010}, 4'b1011};
    tbl[4] = '{16'h789B, 4'b1001, 1'b1, {7'b1111000, 7'b0000000, 7'b0010000, 7'b0000011}, 4'b0110};
    tbl[5] = '{16'hCDE0, 4'b0000, 1'b1, {7'b1000110, 7'b0100001, 7'b0000110, 7'b1000000}, 4'b1111};
    tbl[6] = '{16'h0400, 4'b1000, 1'b1, {7'b1111111, 7'b0011001, 7'b1000000, 7'b1000000}, 4'b0111};

    reset = 1'b1; enable = 1'b0; value = '0; load = 1'b0; dp_mask = '0; blank_lz = 1'b0;
    step();
    step();
    chk_blank("reset");

    // Free run from reset: active is zero, frame_done every 16 cycles.
    reset = 1'b0; enable = 1'b1;
    step();
    scan_run("free", 16'h0000, -1, 16'h0000, 34);

    for (int i = 0; i < 7; i++) begin
      enable = 1'b0; load = 1'b1; value = tbl[i].val; dp_mask = tbl[i].dp;
      blank_lz = tbl[i].blz;
      step();
      load = 1'b0; enable = 1'b1;
      step();
      for (int d = 0; d < 4; d++) begin
        chk($sformatf("v%0d_seg_d%0d", i, d), 32'(Seg), 32'(4'b1111 ^ (4'b0001 << d)));
        chk($sformatf("v%0d_disp_d%0d", i, d), 32'(Display), 32'(tbl[i].disp[7*d +: 7]));
        chk($sformatf("v%0d_dp_d%0d", i, d), 32'(Dp), 32'(tbl[i].dpx[d]));
        if (d < 3) repeat (4) step();
      end
      enable = 1'b0;
      step();
      chk_blank($sformatf("v%0d_off", i));
    end
    blank_lz = 1'b0;

    // Mid-frame load waits for the frame boundary.
    load_idle(16'h1111);
    scan_run("midload", 16'h1111, 5, 16'h0005, 24);
    enable = 1'b0;
    step();

    // Load in the boundary cycle takes effect at the next digit 0.
    load_idle(16'h1111);
    scan_run("bndload", 16'h1111, 14, 16'h2222, 24);
    enable = 1'b0;
    step();

    // Reset during digit 2 with pending data queued.
    load_idle(16'h1111);
    scan_run("prerst", 16'h1111, 7, 16'h9999, 10);
    reset = 1'b1;
    step();
    chk_blank("midrst");
    reset = 1'b0;
    step();
    scan_run("postrst", 16'h0000, -1, 16'h0000, 21);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
